alu_control_mc: RTL and testbench
=================================

Name: alu_control_mc

Overview:
Parametrised successor to the single-cycle ALU control decoder for the RISC core.
- Keeps the combinational aluOp/func → ALU-control mapping.
- Adds two multi-cycle functions, unsigned multiply and unsigned divide, executed by an internal iterative sequencer.
- Sits between the control unit and the EX stage. Drives the ALU select and a pipeline stall, and returns a HI/LO result pair when a multi-cycle op completes.

Parameters:
WIDTH  32  operand/datapath width (≥4)
OP_W  3  aluOp width
FUNC_W  4  func field width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
inp_aluOp  input  OP_W  aluOp from main control
inp_func  input  FUNC_W  func field of instruction
inp_valid  input  1  EX stage holds a live instruction this cycle
inp_flush  input  1  abort any in-flight multi-cycle op
inp_a  input  WIDTH  operand A (multiplicand / dividend)
inp_b  input  WIDTH  operand B (multiplier / divisor)
out_aluControl  output  4  ALU select, combinational
out_stall  output  1  hold the pipeline
out_busy  output  1  sequencer not IDLE
out_done  output  1  one-cycle pulse: out_hi/out_lo valid
out_hi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder
out_lo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient

Behaviour:
Decode (combinational, no reset dependence):
- aluOp 1→1, 2→7, 3→0, 4→8, 5→9; 6, 7→0.
- aluOp 0, func mapping: 0→0, 1→1, 2→5, 3→6, 4→7, 5→3, 6→4, 7→2, 8→8, 9→9, 10→10 (MUL), 11→11 (DIV), 12–15→0.
- is_mc = (aluOp==0) & (func==10 | func==11).

Reset (rst=1 at clock edge):
- state=IDLE; out_busy=0, out_done=0, out_hi=0, out_lo=0.
- Counter and internal registers cleared.
- Reset mid-operation aborts the op; no done pulse follows.

States:
- IDLE: if inp_valid & is_mc & !inp_flush:
  - latch a, b and op; counter=0.
  - DIV with b==0 → DONE directly.
  - otherwise → RUN.
- RUN: one iteration per cycle, WIDTH iterations (counter 0..WIDTH-1). After the last iteration → DONE.
  - MUL: shift-add on a 2W accumulator. If multiplier LSB is set, add multiplicand into the upper half, then shift right by 1 (carry retained).
  - DIV: restoring. Shift {rem, quot} left by 1, trial-subtract divisor from rem; if non-negative, keep the difference and set the quot LSB.
- DONE: out_done=1 for exactly this cycle; out_hi/out_lo updated at DONE entry and held until the next DONE entry or reset. Next state IDLE.

Divide by zero: quotient = all ones, remainder = a. Done pulse arrives 1 cycle after the start cycle.

Latency (start cycle = IDLE cycle with accepted request):
- MUL or nonzero DIV: out_done in cycle start+WIDTH+1.
- DIV by zero: out_done in cycle start+1.

Stall:
- out_stall = (state==IDLE & inp_valid & is_mc & !inp_flush) | (state==RUN).
- Deasserted in the DONE cycle so the instruction retires with the result.
- out_busy = (state!=IDLE).

Flush:
- inp_flush in RUN or DONE → IDLE next cycle, no done pulse (DONE-cycle pulse still visible that cycle); out_hi/out_lo keep their previous values.
- inp_flush in IDLE blocks the start.

Other boundary rules:
- inp_valid/operands ignored while busy; operand changes after the start cycle do not affect the result.
- A new multi-cycle request in the cycle after DONE (state IDLE) is accepted; back-to-back ops are allowed.
- Non-mc ops never stall and never change out_hi/out_lo.
- All arithmetic unsigned. Product width is exactly 2·WIDTH with no truncation. Counter width is clog2(WIDTH)+1.

Test Plan:
- WIDTH=8: aluOp=0, func=10, a=13, b=11, valid one cycle → out_stall high for cycles 0..8; out_done at cycle 9; hi=0x00, lo=0x8F.
- WIDTH=8: MUL a=0xFF, b=0xFF → hi=0xFE, lo=0x01 at cycle 9; a operand changed to 0 at cycle 3 has no effect.
- WIDTH=8: DIV a=200, b=7 → lo=0x1C, hi=0x04 at cycle 9. DIV a=55, b=0 → done at cycle 1, lo=0xFF, hi=0x37.
- Decode sweep: all 8 aluOp × 16 func values → out_aluControl matches the table (e.g. aluOp0/func5→3, aluOp4→8, aluOp0/func13→0); no stall for any non-mc code.
- Flush at cycle 4 of MUL → IDLE at cycle 5, no out_done, hi/lo unchanged. rst at cycle 4 of DIV → all outputs 0 next cycle, no done pulse.
- Back-to-back: MUL done at cycle 9, DIV accepted at cycle 10 → second done at cycle 19; out_done high for exactly one cycle each.

Source files
------------

// File: rtl/alu_control_mc.sv
// ALU control decoder with an iterative unsigned multiply/divide sequencer.
// Decode is purely combinational; MUL/DIV stall the pipeline until a one-cycle done pulse.
module alu_control_mc #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned OP_W   = 3,
   parameter int unsigned FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   inp_aluOp,
   input  logic [FUNC_W-1:0] inp_func,
   input  logic              inp_valid,
   input  logic              inp_flush,
   input  logic [WIDTH-1:0]  inp_a,
   input  logic [WIDTH-1:0]  inp_b,
   output logic [3:0]        out_aluControl,
   output logic              out_stall,
   output logic              out_busy,
   output logic              out_done,
   output logic [WIDTH-1:0]  out_hi,
   output logic [WIDTH-1:0]  out_lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [3:0]         w_func_ctl;
   logic               w_is_mc;
   logic               w_is_div;
   logic               w_start;
   logic               w_last;
   logic [WIDTH-1:0]   w_upper;
   logic [WIDTH-1:0]   w_lower;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_rem_sh;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic [2*WIDTH-1:0] w_acc_nxt;

   always_comb begin
      w_func_ctl = 4'd0;
      case (inp_func)
         FUNC_W'(0):  w_func_ctl = 4'd0;
         FUNC_W'(1):  w_func_ctl = 4'd1;
         FUNC_W'(2):  w_func_ctl = 4'd5;
         FUNC_W'(3):  w_func_ctl = 4'd6;
         FUNC_W'(4):  w_func_ctl = 4'd7;
         FUNC_W'(5):  w_func_ctl = 4'd3;
         FUNC_W'(6):  w_func_ctl = 4'd4;
         FUNC_W'(7):  w_func_ctl = 4'd2;
         FUNC_W'(8):  w_func_ctl = 4'd8;
         FUNC_W'(9):  w_func_ctl = 4'd9;
         FUNC_W'(10): w_func_ctl = 4'd10;
         FUNC_W'(11): w_func_ctl = 4'd11;
         default:     w_func_ctl = 4'd0;
      endcase
   end

   always_comb begin
      out_aluControl = 4'd0;
      case (inp_aluOp)
         OP_W'(0): out_aluControl = w_func_ctl;
         OP_W'(1): out_aluControl = 4'd1;
         OP_W'(2): out_aluControl = 4'd7;
         OP_W'(4): out_aluControl = 4'd8;
         OP_W'(5): out_aluControl = 4'd9;
         default:  out_aluControl = 4'd0;
      endcase
   end

   assign w_is_mc  = (inp_aluOp == '0) &
                     ((inp_func == FUNC_W'(10)) | (inp_func == FUNC_W'(11)));
   assign w_is_div = (inp_func == FUNC_W'(11));
   assign w_start  = (r_state == ST_IDLE) & inp_valid & w_is_mc & ~inp_flush;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // MUL: acc = {partial product, multiplier}; carry out of the add lands in the MSB on shift
   assign w_upper   = r_acc[2*WIDTH-1:WIDTH];
   assign w_lower   = r_acc[WIDTH-1:0];
   assign w_add     = w_lower[0] ? ({1'b0, w_upper} + {1'b0, r_opnd}) : {1'b0, w_upper};
   assign w_mul_nxt = {w_add, w_lower[WIDTH-1:1]};

   // DIV: acc = {remainder, quotient}; shifted remainder needs one extra bit for the compare
   assign w_rem_sh  = {w_upper, w_lower[WIDTH-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
   assign w_div_nxt = w_ge ? {w_rem_sh[WIDTH-1:0] - r_opnd, w_lower[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], w_lower[WIDTH-2:0], 1'b0};
   assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_cnt    <= '0;
                  r_is_div <= w_is_div;
                  if (w_is_div) begin
                     r_opnd <= inp_b;
                     r_acc  <= {{WIDTH{1'b0}}, inp_a};
                     if (inp_b == '0) begin
                        r_state <= ST_DONE;
                        r_hi    <= inp_a;
                        r_lo    <= '1;
                     end else begin
                        r_state <= ST_RUN;
                     end
                  end else begin
                     r_opnd  <= inp_a;
                     r_acc   <= {{WIDTH{1'b0}}, inp_b};
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (inp_flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_hi    <= w_acc_nxt[2*WIDTH-1:WIDTH];
                     r_lo    <= w_acc_nxt[WIDTH-1:0];
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_stall = w_start | (r_state == ST_RUN);
   assign out_busy  = (r_state != ST_IDLE);
   assign out_done  = (r_state == ST_DONE);
   assign out_hi    = r_hi;
   assign out_lo    = r_lo;

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc at WIDTH=8: directed cases with literal results plus random traffic
// checked every cycle against a countdown/arithmetic reference model.
module tb_alu_control_mc;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   aluop;
   logic [3:0]   func;
   logic         valid;
   logic         flush;
   logic [W-1:0] ina;
   logic [W-1:0] inb;
   logic [3:0]   out_ctl;
   logic         out_stall;
   logic         out_busy;
   logic         out_done;
   logic [W-1:0] out_hi;
   logic [W-1:0] out_lo;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   int func_tab[16] = '{0, 1, 5, 6, 7, 3, 4, 2, 8, 9, 10, 11, 0, 0, 0, 0};
   int op_tab[8]    = '{0, 1, 7, 0, 8, 9, 0, 0};

   alu_control_mc #(.WIDTH(W), .OP_W(3), .FUNC_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .inp_aluOp     (aluop),
      .inp_func      (func),
      .inp_valid     (valid),
      .inp_flush     (flush),
      .inp_a         (ina),
      .inp_b         (inb),
      .out_aluControl(out_ctl),
      .out_stall     (out_stall),
      .out_busy      (out_busy),
      .out_done      (out_done),
      .out_hi        (out_hi),
      .out_lo        (out_lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_mc(input logic [2:0] op, input logic [3:0] fn);
      return (op == 3'd0) && (fn == 4'd10 || fn == 4'd11);
   endfunction

   function automatic int exp_ctl(input logic [2:0] op, input logic [3:0] fn);
      return (op == 3'd0) ? func_tab[fn] : op_tab[op];
   endfunction

   // Reference model: m_left counts RUN cycles still to go, m_done marks the done cycle
   int           m_left = 0;
   bit           m_done = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

   always @(posedge clk) begin
      logic [2*W-1:0] prod;
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (flush) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
         end
      end else if (valid && is_mc(aluop, func) && !flush) begin
         if (func == 4'd10) begin
            prod = {{W{1'b0}}, ina} * {{W{1'b0}}, inb};
            p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0]; m_left = W;
         end else if (inb == '0) begin
            m_done = 1'b1; m_hi = ina; m_lo = '1;
         end else begin
            p_hi = ina % inb; p_lo = ina / inb; m_left = W;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ctl", {28'd0, out_ctl}, exp_ctl(aluop, func));
         chk("stall", {31'd0, out_stall},
             {31'd0, (m_left > 0) ||
                     (!m_done && m_left == 0 && valid && is_mc(aluop, func) && !flush)});
         chk("busy", {31'd0, out_busy}, {31'd0, (m_left > 0) || m_done});
         chk("done", {31'd0, out_done}, {31'd0, m_done});
         chk("hi", {24'd0, out_hi}, {24'd0, m_hi});
         chk("lo", {24'd0, out_lo}, {24'd0, m_lo});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one op on an idle cycle, then waits (bounded) for done and checks literal results
   task automatic run_op(input logic [2:0] op, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_cyc, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input string nm);
      int cyc;
      step();
      aluop = op; func = fn; ina = a; inb = b; valid = 1'b1;
      #1;
      chk({nm, "_stall0"}, {31'd0, out_stall}, 32'd1);
      step();
      valid = 1'b0;
      cyc = 1;
      while (out_done !== 1'b1 && cyc < 40) begin
         if (cyc == 3) begin ina = '0; inb = '0; end
         step();
         cyc++;
      end
      chk({nm, "_lat"}, cyc, exp_cyc);
      chk({nm, "_hi"}, {24'd0, out_hi}, {24'd0, eh});
      chk({nm, "_lo"}, {24'd0, out_lo}, {24'd0, el});
   endtask

   initial begin
      int cyc;
      int dcount;
      rst = 1'b1; aluop = '0; func = '0; valid = 1'b0; flush = 1'b0; ina = '0; inb = '0;
      repeat (3) step();
      cmp_en = 1'b1;
      chk("rst_busy", {31'd0, out_busy}, 32'd0);
      chk("rst_hi", {24'd0, out_hi}, 32'd0);
      rst = 1'b0;

      run_op(3'd0, 4'd10, 8'd13, 8'd11, 9, 8'h00, 8'h8F, "mul13x11");
      run_op(3'd0, 4'd10, 8'hFF, 8'hFF, 9, 8'hFE, 8'h01, "mulFFxFF");
      run_op(3'd0, 4'd11, 8'd200, 8'd7, 9, 8'h04, 8'h1C, "div200_7");
      run_op(3'd0, 4'd11, 8'd55, 8'd0, 1, 8'h37, 8'hFF, "div55_0");

      // Flush at cycle 4 of a MUL: no done, previous result held
      step();
      aluop = 3'd0; func = 4'd10; ina = 8'd9; inb = 8'd9; valid = 1'b1;
      step(); valid = 1'b0;
      repeat (3) step();
      flush = 1'b1;
      step(); flush = 1'b0;
      chk("flush_busy", {31'd0, out_busy}, 32'd0);
      dcount = 0;
      repeat (12) begin if (out_done) dcount++; step(); end
      chk("flush_nodone", dcount, 0);
      chk("flush_hi", {24'd0, out_hi}, 32'h37);
      chk("flush_lo", {24'd0, out_lo}, 32'hFF);

      // Reset at cycle 4 of a DIV: everything cleared, no done
      step();
      aluop = 3'd0; func = 4'd11; ina = 8'd99; inb = 8'd5; valid = 1'b1;
      step(); valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step(); rst = 1'b0;
      chk("rstmid_busy", {31'd0, out_busy}, 32'd0);
      chk("rstmid_hi", {24'd0, out_hi}, 32'd0);
      chk("rstmid_lo", {24'd0, out_lo}, 32'd0);
      dcount = 0;
      repeat (12) begin if (out_done) dcount++; step(); end
      chk("rstmid_nodone", dcount, 0);

      // Back-to-back: DIV presented in the MUL done cycle, accepted the cycle after
      run_op(3'd0, 4'd10, 8'd3, 8'd5, 9, 8'h00, 8'h0F, "b2b_mul");
      aluop = 3'd0; func = 4'd11; ina = 8'd100; inb = 8'd9; valid = 1'b1;
      #1;
      chk("b2b_stall_done", {31'd0, out_stall}, 32'd0);
      step();
      chk("b2b_done_off", {31'd0, out_done}, 32'd0);
      chk("b2b_stall_acc", {31'd0, out_stall}, 32'd1);
      step(); valid = 1'b0;
      cyc = 11;
      while (out_done !== 1'b1 && cyc < 60) begin step(); cyc++; end
      chk("b2b_lat", cyc, 19);
      chk("b2b_lo", {24'd0, out_lo}, 32'h0B);
      chk("b2b_hi", {24'd0, out_hi}, 32'h01);
      step();
      chk("b2b_pulse", {31'd0, out_done}, 32'd0);

      // Decode sweep; valid only for non-mc codes so nothing may stall
      for (int op = 0; op < 8; op++) begin
         for (int fn = 0; fn < 16; fn++) begin
            aluop = 3'(op); func = 4'(fn);
            valid = !is_mc(3'(op), 4'(fn));
            step();
         end
      end
      valid = 1'b0;
      aluop = 3'd0; func = 4'd5;  #1; chk("dec_op0_f5", {28'd0, out_ctl}, 32'd3);
      aluop = 3'd4; func = 4'd2;  #1; chk("dec_op4", {28'd0, out_ctl}, 32'd8);
      aluop = 3'd0; func = 4'd13; #1; chk("dec_op0_f13", {28'd0, out_ctl}, 32'd0);
      aluop = 3'd2; func = 4'd0;  #1; chk("dec_op2", {28'd0, out_ctl}, 32'd7);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step();
         rst   = ($urandom_range(0, 299) == 0);
         valid = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 1) == 1) begin
            aluop = 3'd0; func = 4'($urandom_range(10, 11));
         end else begin
            aluop = 3'($urandom_range(0, 7)); func = 4'($urandom_range(0, 15));
         end
         ina = W'($urandom);
         inb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      step();
      rst = 1'b0; valid = 1'b0; flush = 1'b0;
      repeat (2) step();
      cmp_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
